mem_ctrl: RTL

MEM-stage load/store controller in the RISC-V core. It takes the decoded memory operation latched in EX/MEM and converts it into a held size-coded read or write request to the byte-serial memory buffer. While that request is in flight it stalls the pipeline, then sign- or zero-extends the returned load data and hands the register write-back fields to MEM/WB. Non-memory instructions pass straight through with zero latency.

---
 rtl/mem_ctrl_pkg.sv | 51 +++++
 rtl/mem_ctrl_load_ext.sv | 21 ++
 rtl/mem_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller:
// op codes, request size codes, FSM states and common bus constants.
package mem_ctrl_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic        RstEnable  = 1'b1;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_B    = 2'b01;
    localparam logic [1:0] SIZE_H    = 2'b10;
    localparam logic [1:0] SIZE_W    = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mem_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

    // Codes 9-15 fall into the default and behave as NONE.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] size;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: size = SIZE_B;
            MEM_LH, MEM_LHU, MEM_SH: size = SIZE_H;
            MEM_LW, MEM_SW:          size = SIZE_W;
            default:                 size = SIZE_NONE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Sign/zero extension of the raw buffer data according to the load op.
module load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (op)
            MEM_LB:  ext = {{24{raw[7]}}, raw[7:0]};
            MEM_LBU: ext = {24'h0, raw[7:0]};
            MEM_LH:  ext = {{16{raw[15]}}, raw[15:0]};
            MEM_LHU: ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage load/store controller: issues held size-coded requests to the
// byte-serial buffer, stalls the pipeline while in flight, extends load data.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    output logic [1:0]        mem_read_req,
    output logic [1:0]        mem_write_req,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_data_enable,
    output logic              stall_req,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o
);

    mem_state_e        state_q, state_d;
    logic [3:0]        op_q;
    logic [4:0]        wd_q;
    logic              wreg_q;
    logic [31:0]       load_data_q;
    logic [1:0]        read_req_q, write_req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       write_data_q;
    logic [31:0]       load_ext_data;
    logic              is_mem_op;

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr_i[31:ADDR_W];

    assign is_mem_op = op_is_load(mem_op_i) || op_is_store(mem_op_i);

    load_ext u_load_ext (
        .op  (op_q),
        .raw (mem_data_i),
        .ext (load_ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= StIdle;
            op_q         <= MEM_NONE;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            load_data_q  <= ZeroWord;
            read_req_q   <= SIZE_NONE;
            write_req_q  <= SIZE_NONE;
            addr_q       <= '0;
            write_data_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (is_mem_op) begin
                        read_req_q  <= op_is_load(mem_op_i) ? op_size(mem_op_i) : SIZE_NONE;
                        write_req_q <= op_is_store(mem_op_i) ? op_size(mem_op_i) : SIZE_NONE;
                        addr_q      <= mem_addr_i[ADDR_W-1:0];
                        op_q        <= mem_op_i;
                        wd_q        <= wd_i;
                        wreg_q      <= wreg_i;
                        if (op_is_store(mem_op_i)) begin
                            write_data_q <= store_data_i;
                        end
                    end
                end
                StBusy: begin
                    // Drop requests on the completing edge so fetch never sees a stale one.
                    if (mem_data_enable) begin
                        load_data_q <= load_ext_data;
                        read_req_q  <= SIZE_NONE;
                        write_req_q <= SIZE_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        wd_o      = wd_i;
        wreg_o    = wreg_i;
        wdata_o   = wdata_i;
        case (state_q)
            StIdle: begin
                if (is_mem_op) begin
                    stall_req = 1'b1;
                    wreg_o    = 1'b0;
                    wdata_o   = ZeroWord;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                stall_req = 1'b1;
                wd_o      = wd_q;
                wreg_o    = 1'b0;
                wdata_o   = ZeroWord;
                if (mem_data_enable) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                wd_o    = wd_q;
                wreg_o  = op_is_load(op_q) && wreg_q;
                wdata_o = op_is_load(op_q) ? load_data_q : ZeroWord;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Write-back and stall are held quiet for the whole reset cycle.
        if (rst == RstEnable) begin
            stall_req = 1'b0;
            wd_o      = '0;
            wreg_o    = 1'b0;
            wdata_o   = ZeroWord;
        end
    end

    assign mem_read_req   = read_req_q;
    assign mem_write_req  = write_req_q;
    assign mem_addr_o     = addr_q;
    assign mem_write_data = write_data_q;

endmodule
